// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access controller and data memory.
// The controller drives the request side; the memory answers with ack and read data.
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: issues one registered request per
// load/store, freezes the pipeline while it is outstanding, and flags misaligned/timed-out accesses.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Mem_Read_M,
  input  logic              Mem_Write_M,
  input  logic [DATA_W-1:0] ALU_result_M,
  input  logic [DATA_W-1:0] Write_Data_M,
  input  logic              err_clr,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_M,
  output logic              rdata_valid,
  output logic              bus_err,
  mem_access_ctrl_if.master dmem
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic op;
  logic misaligned;

  assign op         = Mem_Read_M | Mem_Write_M;
  assign misaligned = |ALU_result_M[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    stall_out = 1'b1;
    unique case (state_q)
      StIdle: begin
        stall_out = op;
        if (op && misaligned) begin
          state_d = StErr;
        end else if (op) begin
          state_d = StReq;
          cnt_d   = '0;
          addr_d  = ALU_result_M;
          wdata_d = Write_Data_M;
          we_d    = Mem_Write_M;
        end
      end
      StReq: begin
        // An ack arriving in the expiry cycle still completes the access.
        if (dmem.dmem_ack) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d  = dmem.dmem_rdata;
            rvalid_d = 1'b1;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      // Op is deliberately not sampled here; the pipeline advances on this edge.
      StDone: begin
        stall_out = 1'b0;
        state_d   = StIdle;
      end
      StErr: begin
        if (err_clr) begin
          rdata_d = '0;
          state_d = StDone;
        end
      end
    endcase
    req_d = (state_d == StReq);
    err_d = (state_d == StErr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign rdata_M         = rdata_q;
  assign rdata_valid     = rvalid_q;
  assign bus_err         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: an inline memory responder with per-access ack latency and
// a scoreboard of expected completion results popped when the pipeline advances past DONE.
module tb_mem_access_ctrl;
  localparam int unsigned DataW   = 32;
  localparam int unsigned Timeout = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             Mem_Read_M;
  logic             Mem_Write_M;
  logic [DataW-1:0] ALU_result_M;
  logic [DataW-1:0] Write_Data_M;
  logic             err_clr;
  logic             stall_out;
  logic [DataW-1:0] rdata_M;
  logic             rdata_valid;
  logic             bus_err;

  mem_access_ctrl_if #(.DATA_W(DataW)) dmem_bus ();

  mem_access_ctrl #(
    .DATA_W (DataW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Mem_Read_M  (Mem_Read_M),
    .Mem_Write_M (Mem_Write_M),
    .ALU_result_M(ALU_result_M),
    .Write_Data_M(Write_Data_M),
    .err_clr     (err_clr),
    .stall_out   (stall_out),
    .rdata_M     (rdata_M),
    .rdata_valid (rdata_valid),
    .bus_err     (bus_err),
    .dmem        (dmem_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid;
    logic [DataW-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  logic [DataW-1:0] model_rdata = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Op deasserted; optionally a stray ack while no request is pending.
  task automatic idle(input int n, input logic stray_ack);
    Mem_Read_M  = 1'b0;
    Mem_Write_M = 1'b0;
    err_clr     = 1'b0;
    for (int i = 0; i < n; i++) begin
      dmem_bus.dmem_ack   = stray_ack;
      dmem_bus.dmem_rdata = $urandom();
      #1;
      check("idle stall", stall_out, 1'b0);
      check("idle req", dmem_bus.dmem_req, 1'b0);
      check("idle rvalid", rdata_valid, 1'b0);
      check("idle bus_err", bus_err, 1'b0);
      check("idle rdata hold", rdata_M, model_rdata);
      @(negedge clk);
    end
    dmem_bus.dmem_ack = 1'b0;
  endtask

  // One MEM-stage instruction: held until the pipeline advances (stall_out low at an edge).
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_k,
                        input logic [31:0] mem_data, input int clr_after,
                        input int exp_stall, input int exp_req, input logic exp_err);
    int   stall_n = 0;
    int   req_n   = 0;
    int   err_n   = 0;
    logic done    = 1'b0;
    exp_t exp_r;
    Mem_Read_M   = rd;
    Mem_Write_M  = wr;
    ALU_result_M = addr;
    Write_Data_M = wd;
    if (exp_err) model_rdata = '0;
    else if (rd && !wr) model_rdata = mem_data;
    exp_r.valid = rd && !wr && !exp_err;
    exp_r.data  = model_rdata;
    sb_q.push_back(exp_r);
    for (int c = 0; c < 100 && !done; c++) begin
      dmem_bus.dmem_ack   = dmem_bus.dmem_req && (req_n == ack_k);
      dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? mem_data : $urandom();
      err_clr             = bus_err && (err_n == clr_after);
      #1;
      if (stall_out) stall_n++;
      if (dmem_bus.dmem_req) begin
        check({tag, " addr"}, dmem_bus.dmem_addr, addr);
        check({tag, " we"}, dmem_bus.dmem_we, wr);
        check({tag, " wdata"}, dmem_bus.dmem_wdata, wd);
        req_n++;
      end
      if (bus_err) begin
        check({tag, " req in err"}, dmem_bus.dmem_req, 1'b0);
        err_n++;
      end
      if (!stall_out) begin
        check({tag, " sb depth"}, sb_q.size(), 1);
        exp_r = sb_q.pop_front();
        check({tag, " rvalid"}, rdata_valid, exp_r.valid);
        check({tag, " rdata"}, rdata_M, exp_r.data);
        check({tag, " err in done"}, bus_err, 1'b0);
        done = 1'b1;
      end
      @(negedge clk);
    end
    Mem_Read_M        = 1'b0;
    Mem_Write_M       = 1'b0;
    err_clr           = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    check({tag, " completed"}, done, 1'b1);
    check({tag, " stall cycles"}, stall_n, exp_stall);
    check({tag, " req cycles"}, req_n, exp_req);
    check({tag, " saw err"}, err_n != 0, exp_err);
  endtask

  initial begin
    rst                 = 1'b1;
    Mem_Read_M          = 1'b1;
    Mem_Write_M         = 1'b0;
    ALU_result_M        = 32'h0000_0040;
    Write_Data_M        = 32'h0;
    err_clr             = 1'b0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst req", dmem_bus.dmem_req, 1'b0);
    check("rst we", dmem_bus.dmem_we, 1'b0);
    check("rst addr", dmem_bus.dmem_addr, 32'h0);
    check("rst wdata", dmem_bus.dmem_wdata, 32'h0);
    check("rst rdata", rdata_M, 32'h0);
    check("rst rvalid", rdata_valid, 1'b0);
    check("rst bus_err", bus_err, 1'b0);
    check("rst stall", stall_out, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req", dmem_bus.dmem_req, 1'b1);
    check("post-rst addr", dmem_bus.dmem_addr, 32'h0000_0040);
    // Asynchronous reset in the middle of REQ, then a late ack that must be ignored.
    #2 rst = 1'b1;
    #1;
    check("mid-req rst req", dmem_bus.dmem_req, 1'b0);
    check("mid-req rst stall", stall_out, 1'b1);
    Mem_Read_M = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);

    access("load ack0", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 0, 2, 1, 1'b0);
    idle(2, 1'b1);
    access("store wait4", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 32'h0, 0, 6, 5, 1'b0);
    idle(1, 1'b0);
    access("load timeout", 1'b1, 1'b0, 32'h0000_0030, 32'h0, -1, 32'h0, 2, 19, 15, 1'b1);
    access("load misaligned", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 0, 2, 0, 1'b1);
    access("load ack at expiry", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 14, 32'hA5A5_0F0F, 0,
           16, 15, 1'b0);
    access("b2b load a", 1'b1, 1'b0, 32'h0000_0050, 32'h0, 0, 32'h1111_2222, 0, 2, 1, 1'b0);
    access("b2b load b", 1'b1, 1'b0, 32'h0000_0054, 32'h0, 1, 32'h3333_4444, 0, 3, 2, 1'b0);
    access("rd+wr", 1'b1, 1'b1, 32'h0000_0058, 32'hCAFE_F00D, 0, 32'h5555_6666, 0, 2, 1, 1'b0);
    idle(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
